// File: rtl/rv_isa_pkg.sv
// Shared RV32I definitions: base opcodes and the loader state encoding.
package rv_isa_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: decoded RV32I fields -> 32-bit instruction word.
// legal_o is low for opcodes outside the supported base set; word_o is 0 then.
module instr_field_pack
    import rv_isa_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // Select the bit layout of the instruction format implied by the opcode.
    always_comb begin
        word_o  = 32'h0;
        legal_o = 1'b1;
        case (opcode)
            OP_R:
                word_o = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_LOAD, OP_IMM, OP_JALR, OP_SYS:
                word_o = {imm[11:0], rs1, funct3, rd, opcode};
            OP_STORE:
                word_o = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            OP_BRANCH:
                word_o = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            OP_LUI, OP_AUIPC:
                word_o = {imm[31:12], rd, opcode};
            OP_JAL:
                word_o = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default:
                legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction memory loader: packs field tuples into RV32I words and writes
// them to consecutive word addresses, one stage of output registering.
module instr_encode_loader
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;   // address for the next legal word
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;       // legal tuples taken, including the pending one
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;         // words accepted by memory
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;

    logic [31:0] pack_word;
    logic        pack_legal;
    logic        in_ready_c;
    logic        tuple_fire;
    logic        mem_fire;

    instr_field_pack u_pack (
        .opcode  (opcode),
        .rd      (rd),
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct7  (funct7),
        .imm     (imm),
        .word_o  (pack_word),
        .legal_o (pack_legal)
    );

    // A new tuple may enter only if the output register is free or draining this cycle.
    assign in_ready_c = (state_q == ST_LOAD) && (acc_cnt_q < num_q) && (!mem_we_q || mem_ready);
    assign tuple_fire = in_valid && in_ready_c;
    assign mem_fire   = mem_we_q && mem_ready;

    // Next-state logic: load setup on start, word accept/retire bookkeeping in LOAD.
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        num_d       = num_q;
        acc_cnt_d   = acc_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    next_addr_d = base_addr & ~ADDR_W'(3);
                    num_d       = num_words;
                    acc_cnt_d   = '0;
                    wr_cnt_d    = '0;
                    err_d       = 1'b0;
                end
            end
            ST_LOAD: begin
                if (mem_fire) begin
                    mem_we_d = 1'b0;
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
                if (tuple_fire) begin
                    if (pack_legal) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = next_addr_q;
                        mem_wdata_d = pack_word;
                        next_addr_d = next_addr_q + ADDR_W'(4);
                        acc_cnt_d   = acc_cnt_q + CNT_W'(1);
                    end else begin
                        // Illegal tuples are consumed but never counted or written.
                        err_d = 1'b1;
                    end
                end
                // Finish in the same edge that retires the last word.
                if ((wr_cnt_d == num_q) && !mem_we_d) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any pending write immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            next_addr_q <= '0;
            num_q       <= '0;
            acc_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            num_q       <= num_d;
            acc_cnt_q   <= acc_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == ST_LOAD);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct7    (funct7),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } tuple_t;

    typedef struct {
        string       name;
        tuple_t      t;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic tuple_t mk(input logic [6:0] op, input logic [4:0] rdv, input logic [2:0] f3,
                                  input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] f7,
                                  input logic [31:0] iv);
        tuple_t t;
        t.op = op; t.rd = rdv; t.f3 = f3; t.rs1 = r1; t.rs2 = r2; t.f7 = f7; t.imm = iv;
        return t;
    endfunction

    // Reference encoder written from the ISA field positions with shifts and masks.
    // Returns {legal, word}.
    function automatic logic [32:0] ref_pack(input tuple_t t);
        int unsigned op, rdv, f3, r1, r2, f7, iv, w;
        bit legal;
        op = 32'(t.op); rdv = 32'(t.rd); f3 = 32'(t.f3);
        r1 = 32'(t.rs1); r2 = 32'(t.rs2); f7 = 32'(t.f7); iv = t.imm;
        legal = 1'b1;
        w = 0;
        case (op)
            32'h33: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | op;
            32'h03, 32'h13, 32'h67, 32'h73:
                w = ((iv % 4096) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | op;
            32'h23: w = (((iv >> 5) % 128) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                        | ((iv % 32) << 7) | op;
            32'h63: w = (((iv >> 12) % 2) << 31) | (((iv >> 5) % 64) << 25) | (r2 << 20)
                        | (r1 << 15) | (f3 << 12) | (((iv >> 1) % 16) << 8)
                        | (((iv >> 11) % 2) << 7) | op;
            32'h37, 32'h17: w = (iv & 32'hFFFF_F000) | (rdv << 7) | op;
            32'h6F: w = (((iv >> 20) % 2) << 31) | (((iv >> 1) % 1024) << 21)
                        | (((iv >> 11) % 2) << 20) | (((iv >> 12) % 256) << 12) | (rdv << 7) | op;
            default: legal = 1'b0;
        endcase
        return {legal, w};
    endfunction

    function automatic tuple_t rand_tuple(input bit want_legal);
        logic [6:0] ops [10];
        logic [32:0] r;
        tuple_t t;
        ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        t = mk(ops[$urandom_range(0, 9)], 5'($urandom), 3'($urandom), 5'($urandom),
               5'($urandom), 7'($urandom), $urandom);
        if (!want_legal) begin
            for (int k = 0; k < 200; k++) begin
                t.op = 7'($urandom);
                r = ref_pack(t);
                if (!r[32]) break;
            end
            if (r[32]) t.op = 7'h7F;
        end
        return t;
    endfunction

    task automatic drive(input tuple_t t);
        opcode = t.op; rd = t.rd; funct3 = t.f3; rs1 = t.rs1; rs2 = t.rs2;
        funct7 = t.f7; imm = t.imm;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] num);
        start = 1'b1;
        base_addr = base;
        num_words = num;
        step();
        start = 1'b0;
    endtask

    // Randomized load checked against an in-order list of expected writes.
    task automatic run_load(input logic [31:0] base, input int num, input int ill_pct,
                            input int stall_pct, input bit inject);
        tuple_t      tq[$];
        logic [31:0] exp_addr[$];
        logic [31:0] exp_word[$];
        logic [32:0] r;
        tuple_t      t;
        int ptr, legal_acc, written, cyc, pending;
        bit err_seen, fire, wfire, fire_legal;
        for (int k = 0; k < num; k++) begin
            if ($urandom_range(0, 99) < ill_pct) tq.push_back(rand_tuple(1'b0));
            t = rand_tuple(1'b1);
            tq.push_back(t);
            r = ref_pack(t);
            exp_word.push_back(r[31:0]);
            exp_addr.push_back({base[31:2], 2'b00} + 32'(4 * k));
        end
        ptr = 0; legal_acc = 0; written = 0; cyc = 0; err_seen = 1'b0;
        do_start(base, 16'(num));
        while (written < num && cyc < 40 * num + 100) begin
            cyc++;
            mem_ready = ($urandom_range(0, 99) >= stall_pct);
            in_valid  = (ptr < tq.size()) && ($urandom_range(0, 99) < 75);
            if (ptr < tq.size()) drive(tq[ptr]);
            else drive(rand_tuple(1'b1));
            start     = inject && ($urandom_range(0, 7) == 0);
            base_addr = $urandom;
            num_words = 16'($urandom_range(1, 9));
            #1;
            pending = legal_acc - written;
            chk("rnd_done", 32'(done), 32'(0));
            chk("rnd_busy", 32'(busy), 32'(1));
            chk("rnd_err", 32'(err), 32'(err_seen));
            chk("rnd_mem_we", 32'(mem_we), 32'(pending > 0));
            chk("rnd_in_ready", 32'(in_ready),
                32'((legal_acc < num) && (pending == 0 || mem_ready)));
            if (mem_we && written < num) begin
                chk("rnd_addr", mem_addr, exp_addr[written]);
                chk("rnd_data", mem_wdata, exp_word[written]);
            end
            fire  = in_valid && in_ready;
            wfire = mem_we && mem_ready;
            fire_legal = 1'b0;
            if (fire && ptr < tq.size()) begin
                r = ref_pack(tq[ptr]);
                fire_legal = r[32];
            end
            step();
            if (fire) begin
                if (fire_legal) legal_acc++;
                else err_seen = 1'b1;
                ptr++;
            end
            if (wfire) written++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (written < num) chk("rnd_timeout_writes", 32'(written), 32'(num));
        #1;
        chk("rnd_end_done", 32'(done), 32'(1));
        chk("rnd_end_busy", 32'(busy), 32'(0));
        chk("rnd_end_mem_we", 32'(mem_we), 32'(0));
        chk("rnd_end_err", 32'(err), 32'(err_seen));
        $display("[TB] load base=0x%08h num=%0d tuples=%0d cycles=%0d", base, num, tq.size(), cyc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        tuple_t t_add, t_addi, t_bad;

        vecs[0] = '{"add",       mk(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h0),        32'h002081B3};
        vecs[1] = '{"addi_m1",   mk(7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFF), 32'hFFF00293};
        vecs[2] = '{"sw",        mk(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'd8),        32'h0020A423};
        vecs[3] = '{"beq",       mk(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'd16),       32'h00208863};
        vecs[4] = '{"jal",       mk(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd2048),     32'h001000EF};
        vecs[5] = '{"lui",       mk(7'h37, 5'd7, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000), 32'h123453B7};
        vecs[6] = '{"lui_junk",  mk(7'h37, 5'd7, 3'd7, 5'd31, 5'd31, 7'h7F, 32'h12345FFF), 32'h123453B7};
        vecs[7] = '{"lw_m4",     mk(7'h03, 5'd6, 3'd2, 5'd2, 5'd0, 7'h00, 32'hFFFFFFFC), 32'hFFC12303};
        vecs[8] = '{"sub",       mk(7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'h0),        32'h403100B3};
        vecs[9] = '{"jal_m4",    mk(7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFC), 32'hFFDFF06F};
        t_add  = vecs[0].t;
        t_addi = vecs[1].t;
        t_bad  = mk(7'h7F, 5'd9, 3'd1, 5'd4, 5'd5, 7'h11, 32'h1234);

        reset = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        in_valid = 1'b0; mem_ready = 1'b1; drive(t_add);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        step();

        // Basic two-word load at full throughput.
        do_start(32'h100, 16'd2);
        mem_ready = 1'b1; drive(t_add); in_valid = 1'b1;
        #1;
        chk("basic_in_ready", 32'(in_ready), 1);
        chk("basic_busy", 32'(busy), 1);
        chk("basic_we0", 32'(mem_we), 0);
        step();
        drive(t_addi);
        #1;
        chk("basic_we1", 32'(mem_we), 1);
        chk("basic_addr1", mem_addr, 32'h100);
        chk("basic_data1", mem_wdata, 32'h002081B3);
        chk("basic_in_ready2", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        #1;
        chk("basic_we2", 32'(mem_we), 1);
        chk("basic_addr2", mem_addr, 32'h104);
        chk("basic_data2", mem_wdata, 32'hFFF00293);
        chk("basic_done_early", 32'(done), 0);
        step();
        #1;
        chk("basic_we_drop", 32'(mem_we), 0);
        chk("basic_done", 32'(done), 1);
        chk("basic_busy_end", 32'(busy), 0);
        $display("[TB] basic two-word load checked");

        // Same load with the first write stalled for three cycles.
        do_start(32'h100, 16'd2);
        mem_ready = 1'b1; drive(t_add); in_valid = 1'b1;
        step();
        drive(t_addi); mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_we", 32'(mem_we), 1);
            chk("stall_addr", mem_addr, 32'h100);
            chk("stall_data", mem_wdata, 32'h002081B3);
            chk("stall_in_ready", 32'(in_ready), 0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        #1;
        chk("stall_we2", 32'(mem_we), 1);
        chk("stall_addr2", mem_addr, 32'h104);
        chk("stall_data2", mem_wdata, 32'hFFF00293);
        step();
        #1;
        chk("stall_done", 32'(done), 1);
        chk("stall_we_end", 32'(mem_we), 0);
        $display("[TB] stalled load checked");

        // Packing table: one single-word load per vector.
        for (int i = 0; i < 10; i++) begin
            do_start(32'h200 + 32'(i * 16), 16'd1);
            drive(vecs[i].t); in_valid = 1'b1; mem_ready = 1'b1;
            #1;
            chk({"tbl_in_ready_", vecs[i].name}, 32'(in_ready), 1);
            step();
            in_valid = 1'b0;
            #1;
            chk({"tbl_we_", vecs[i].name}, 32'(mem_we), 1);
            chk({"tbl_addr_", vecs[i].name}, mem_addr, 32'h200 + 32'(i * 16));
            chk({"tbl_data_", vecs[i].name}, mem_wdata, vecs[i].exp);
            step();
            #1;
            chk({"tbl_done_", vecs[i].name}, 32'(done), 1);
            $display("[TB] vector %s word=0x%08h", vecs[i].name, mem_wdata);
        end

        // Unsupported opcode first, then a legal tuple.
        do_start(32'h300, 16'd1);
        mem_ready = 1'b1; drive(t_bad); in_valid = 1'b1;
        #1;
        chk("ill_in_ready", 32'(in_ready), 1);
        step();
        #1;
        chk("ill_err", 32'(err), 1);
        chk("ill_no_we", 32'(mem_we), 0);
        chk("ill_still_busy", 32'(busy), 1);
        drive(t_add);
        chk("ill_in_ready2", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        #1;
        chk("ill_we", 32'(mem_we), 1);
        chk("ill_addr", mem_addr, 32'h300);
        chk("ill_data", mem_wdata, 32'h002081B3);
        step();
        #1;
        chk("ill_done", 32'(done), 1);
        chk("ill_err_sticky", 32'(err), 1);
        $display("[TB] unsupported opcode load checked");

        // Zero-length load: also clears err.
        in_valid = 1'b1;
        do_start(32'h500, 16'd0);
        #1;
        chk("zero_err_clr", 32'(err), 0);
        chk("zero_busy", 32'(busy), 1);
        chk("zero_done0", 32'(done), 0);
        chk("zero_in_ready", 32'(in_ready), 0);
        chk("zero_we", 32'(mem_we), 0);
        step();
        #1;
        chk("zero_done", 32'(done), 1);
        chk("zero_we2", 32'(mem_we), 0);
        in_valid = 1'b0;
        $display("[TB] zero-length load checked");

        // Asynchronous reset in the middle of a stalled write.
        do_start(32'h600, 16'd4);
        drive(t_add); in_valid = 1'b1; mem_ready = 1'b0;
        step();
        #1;
        chk("mid_we_before", 32'(mem_we), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_we", 32'(mem_we), 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_data", mem_wdata, 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_in_ready", 32'(in_ready), 0);
        step();
        step();
        reset = 1'b1;
        mem_ready = 1'b1;
        step();
        #1;
        chk("mid_post_we", 32'(mem_we), 0);
        chk("mid_post_done", 32'(done), 0);
        chk("mid_post_busy", 32'(busy), 0);
        chk("mid_post_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        $display("[TB] mid-load reset checked");

        // Address wrap and randomized loads.
        run_load(32'hFFFFFFFC, 2, 0, 30, 1'b0);
        run_load(32'hFFFFFFF7, 3, 30, 30, 1'b1);
        for (int n = 0; n < 16; n++) begin
            run_load($urandom, $urandom_range(1, 12), 25, 35, n[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
